// File: rtl/sev_seg_scanner.sv
// -----------------------------------------------------------------------------
// sev_seg_scanner
//
// Time-multiplexes NUM_DIGITS hex digits onto one shared active-low segment bus
// with active-low anode strobes. Each digit is lit for SCAN_DIV clk cycles.
// Display data is double-buffered: a load writes the pending copy, which is
// copied to the active copy at the end of a full scan so a frame never tears.
//
// Parameters:
//   NUM_DIGITS  number of digits scanned (2..16)
//   SCAN_DIV    clk cycles each digit is lit (>= 2)
//   IDX_W       digit index width, derived from NUM_DIGITS (do not override)
//
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   load        one-cycle strobe capturing digits_in / dp_in / en_in
//   digits_in   hex nibbles, digit i at [4i+3:4i]
//   dp_in       decimal point request per digit, 1 = lit
//   en_in       digit enable, 0 = digit dark
//   Seg         active-low segments, Seg[0]=a .. Seg[6]=g
//   DP          active-low decimal point
//   AN          active-low anodes, at most one low
//   busy        a load is pending and not yet applied
//   frame_done  one-cycle pulse after the last digit of each scan
//
// Build option:
//   SEV_SEG_LZB_EN  when defined, leading zeros of the active copy are blanked
//                   (digit 0 is never blanked; disabled digits are skipped when
//                   deciding whether a zero is leading).
// -----------------------------------------------------------------------------
module sev_seg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    output logic [6:0]              Seg,
    output logic                    DP,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int               DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  boundary;

    logic [3:0]            pend_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] pend_dp;
    logic [NUM_DIGITS-1:0] pend_en;
    logic [3:0]            act_digit  [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] act_dp;
    logic [NUM_DIGITS-1:0] act_en;

    logic [NUM_DIGITS-1:0] lzb_blank;
    logic                  lit;
    logic [6:0]            seg_nx;
    logic                  dp_nx;
    logic [NUM_DIGITS-1:0] an_nx;

    // Segment patterns, bit order g..a, active low.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick     = (div_cnt == DIV_LAST);
    assign boundary = tick && (idx == IDX_LAST);

    // Prescaler, scan index and end-of-frame pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt    <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            frame_done <= boundary;
        end
    end

    // Double buffer. A load that lands on the boundary cycle bypasses the
    // pending stage and goes straight to active, so busy never spans a
    // frame for it and nothing is lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                pend_digit[i] <= '0;
                act_digit[i]  <= '0;
            end
            pend_dp <= '0;
            pend_en <= '0;
            act_dp  <= '0;
            act_en  <= '0;
            busy    <= 1'b0;
        end else begin
            if (load) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    pend_digit[i] <= digits_in[4*i +: 4];
                end
                pend_dp <= dp_in;
                pend_en <= en_in;
            end

            if (boundary && load) begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    act_digit[i] <= digits_in[4*i +: 4];
                end
                act_dp <= dp_in;
                act_en <= en_in;
                busy   <= 1'b0;
            end else if (boundary && busy) begin
                act_digit <= pend_digit;
                act_dp    <= pend_dp;
                act_en    <= pend_en;
                busy      <= 1'b0;
            end else if (load) begin
                busy <= 1'b1;
            end
        end
    end

`ifdef SEV_SEG_LZB_EN
    logic lzb_run;

    // Walk from the most significant digit down. lzb_run stays set while every
    // enabled digit seen so far is a zero with its decimal point clear.
    always_comb begin
        lzb_blank = '0;
        lzb_run   = 1'b1;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            if (lzb_run && act_digit[NUM_DIGITS-k] == 4'h0 && !act_dp[NUM_DIGITS-k]) begin
                lzb_blank[NUM_DIGITS-k] = 1'b1;
            end
            if (act_en[NUM_DIGITS-k] &&
                (act_digit[NUM_DIGITS-k] != 4'h0 || act_dp[NUM_DIGITS-k])) begin
                lzb_run = 1'b0;
            end
        end
    end
`else
    assign lzb_blank = '0;
`endif

    // Output stage: computed from the current idx and registered, so anodes,
    // segments and DP all switch on the same edge.
    always_comb begin
        an_nx  = '1;
        seg_nx = 7'h7F;
        dp_nx  = 1'b1;
        lit    = act_en[idx] && !lzb_blank[idx];
        if (lit) begin
            an_nx[idx] = 1'b0;
            seg_nx     = hex_to_seg(act_digit[idx]);
            dp_nx      = !act_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            AN  <= '1;
            Seg <= 7'h7F;
            DP  <= 1'b1;
        end else begin
            AN  <= an_nx;
            Seg <= seg_nx;
            DP  <= dp_nx;
        end
    end

endmodule

// File: doc/sev_seg_scanner.md
Name: sev_seg_scanner

Overview:
- Parametrised successor to the fixed 8-digit seven-segment controller: time-multiplexes NUM_DIGITS hex digits onto one shared segment bus with anode strobes.
- Adds a programmable scan rate, per-digit enable and decimal point, and a tear-free double-buffered load.
- Sits between the board top-level (switch/datapath values) and the CA..CG/DP/AN pins.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (legal 2..16).
- SCAN_DIV, 100000, clk cycles each digit is lit (legal >= 2).
- IDX_W, $clog2(NUM_DIGITS), digit index width (derived, not overridden).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- load  in  1  one-cycle strobe; captures digits_in/dp_in/en_in
- digits_in  in  4*NUM_DIGITS  hex nibbles, digit i at [4i+3:4i]
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- en_in  in  NUM_DIGITS  digit enable, 0 = digit dark
- Seg  out  7  active-low segments, Seg[0]=a .. Seg[6]=g
- DP  out  1  active-low decimal point
- AN  out  NUM_DIGITS  active-low anodes, one-hot-low when lit
- busy  out  1  pending load not yet applied
- frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (async, resetn=0): div_cnt=0, idx=0, pending and active registers all 0 (all digits disabled), busy=0, frame_done=0, AN=all ones, Seg=7'h7F, DP=1. Outputs stay dark until the first load is applied.
- Prescaler: div_cnt counts 0..SCAN_DIV-1 and wraps. tick=1 when div_cnt==SCAN_DIV-1.
- Scan: idx advances on tick, wrapping NUM_DIGITS-1 -> 0. boundary = tick and idx==NUM_DIGITS-1.
- frame_done is registered and high for the cycle after the boundary cycle.
- Load: on load=1, digits_in/dp_in/en_in are written to pending and busy is set to 1.
- Apply: on boundary with busy=1, pending is copied to active and busy clears.
- load during busy overwrites pending; last write wins.
- load and boundary in the same cycle: the new inputs go to both pending and active, and busy ends 0. Nothing is lost and no update is stalled by a frame.
- Output stage is registered, one cycle behind idx. For the digit at idx:
  - AN = ~(active_en[idx] << idx).
  - Seg = decode(active_digit[idx]), or 7'h7F if the digit is disabled.
  - DP = ~(active_dp[idx] & active_en[idx]).
- Decode (hex, bits g..a): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Exactly one anode is ever low, or none. No ghosting: AN and Seg change in the same registered edge.
- Mid-operation reset returns immediately to the reset state. Pending data is discarded.

Optional Feature:
- Macro SEV_SEG_LZB_EN enables leading-zero blanking on the active copy.
- When defined: digit i (i>0) is forced dark (AN bit 1, Seg 7'h7F, DP 1) if:
  - active_digit[i]==0, and
  - active_dp[i]==0, and
  - every higher enabled digit is also zero with dp clear.
- Digit 0 is never blanked. Disabled digits do not stop blanking below them.
- When undefined: zeros display as "0", and no extra logic is present.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4 unless stated):
- Reset, no load -> AN=4'hF, Seg=7'h7F, DP=1 for 2 frames. frame_done pulses every 16 cycles.
- load digits_in=16'h3210, en_in=4'hF, dp_in=0 mid-frame -> busy=1 until the boundary. The next frame shows AN E,D,B,7 with Seg 40,79,24,30, each digit lit for 4 cycles.
- Two loads in one frame (16'h1111, then 16'hABCD) -> only ABCD is displayed (Seg 21,46,03,08 for digits 0..3). busy clears at the boundary.
- load coincident with the boundary cycle -> busy stays 0 and the new values display from the first digit of the next frame.
- en_in=4'b0101, dp_in=4'b0001 -> AN shows only E and B patterns. DP=0 only while digit 0 is lit. Other slots are fully dark.
- With SEV_SEG_LZB_EN: digits_in=16'h0050, all enabled -> digits 3,2 dark, digits 1,0 show 12,40. Without the macro -> 40,40,12,40.
